// File: rtl/rate_divider_pkg.sv
// Shared constants and the divisor helper for rate_divider.
package rate_divider_pkg;

  localparam logic [1:0] SPEED_FULL       = 2'b00;
  localparam logic [1:0] SPEED_1HZ        = 2'b01;
  localparam logic [1:0] SPEED_HALF_HZ    = 2'b10;
  localparam logic [1:0] SPEED_QUARTER_HZ = 2'b11;

  // Wide enough that 4*freq-1 never overflows for any 32-bit freq.
  localparam int DIV_W = 34;

  typedef enum logic {
    ST_UNLOADED = 1'b0,
    ST_RUNNING  = 1'b1
  } state_e;

  function automatic logic [DIV_W-1:0] divisor_minus1(input logic [1:0] speed,
                                                      input int unsigned freq);
    logic [DIV_W-1:0] f;
    logic [DIV_W-1:0] result;
    f = DIV_W'(freq);
    result = '0;
    case (speed)
      SPEED_FULL:       result = '0;
      SPEED_1HZ:        result = f - 1'b1;
      SPEED_HALF_HZ:    result = (f << 1) - 1'b1;
      SPEED_QUARTER_HZ: result = (f << 2) - 1'b1;
      default:          result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Clock-rate divider emitting a one-cycle Enable pulse every D(Speed) cycles.
// Optional saturating pulse counter behind RATE_DIVIDER_PULSE_COUNT_EN.
module rate_divider
  import rate_divider_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int CNT_W           = $clog2(4 * CLOCK_FREQUENCY)
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic        Clear,
  input  logic [1:0]  Speed,
  output logic        Enable,
  output logic [15:0] PulseCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       speed_q, speed_d;
  logic             enable_q, enable_d;

  logic [DIV_W-1:0] reload_new;
  logic [DIV_W-1:0] reload_cur;

  assign reload_new = divisor_minus1(Speed, CLOCK_FREQUENCY);
  assign reload_cur = divisor_minus1(speed_q, CLOCK_FREQUENCY);

  // Branch order below is the priority order: load, clear, speed change, pause, pulse, count.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    speed_d  = speed_q;
    enable_d = 1'b0;
    if (state_q == ST_UNLOADED) begin
      count_d = reload_new[CNT_W-1:0];
      speed_d = Speed;
      state_d = ST_RUNNING;
    end else if (Clear || (Speed != speed_q)) begin
      count_d = reload_new[CNT_W-1:0];
      speed_d = Speed;
    end else if (!Run) begin
      count_d = count_q;
    end else if (count_q == '0) begin
      enable_d = 1'b1;
      count_d  = reload_cur[CNT_W-1:0];
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_UNLOADED;
      count_q  <= '0;
      speed_q  <= SPEED_FULL;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      speed_q  <= speed_d;
      enable_q <= enable_d;
    end
  end

  assign Enable = enable_q;

`ifdef RATE_DIVIDER_PULSE_COUNT_EN
  logic [15:0] pulse_cnt_q, pulse_cnt_d;

  // Clear wins over any increment; a speed change leaves the count alone.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (Clear) begin
      pulse_cnt_d = '0;
    end else if (enable_d && (pulse_cnt_q != 16'hFFFF)) begin
      pulse_cnt_d = pulse_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign PulseCount = pulse_cnt_q;
`else
  assign PulseCount = 16'h0000;
`endif

endmodule

// File: tb/tb_rate_divider.sv
// Directed plus randomized bench for rate_divider (CLOCK_FREQUENCY=4, D = 1/4/8/16).
module tb_rate_divider;

  localparam int F = 4;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic        Clear;
  logic [1:0]  Speed;
  logic        Enable;
  logic [15:0] PulseCount;

  int vectors;
  int miscompares;

  // Reference model: running edges elapsed since the last (re)start of a period.
  bit          m_loaded;
  logic [1:0]  m_speed;
  int          m_elapsed;
  logic        m_en;
  logic [15:0] m_pc;

  rate_divider #(.CLOCK_FREQUENCY(F)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Run        (Run),
    .Clear      (Clear),
    .Speed      (Speed),
    .Enable     (Enable),
    .PulseCount (PulseCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int period_of(input logic [1:0] spd);
    case (spd)
      2'b00:   return 1;
      2'b01:   return F;
      2'b10:   return 2 * F;
      default: return 4 * F;
    endcase
  endfunction

  task automatic model_reset();
    m_loaded  = 1'b0;
    m_speed   = 2'b00;
    m_elapsed = 0;
    m_en      = 1'b0;
    m_pc      = 16'h0000;
  endtask

  task automatic model_edge(input logic run, input logic clr, input logic [1:0] spd);
    if (!m_loaded || clr || (spd != m_speed)) begin
      m_loaded  = 1'b1;
      m_speed   = spd;
      m_elapsed = 0;
      m_en      = 1'b0;
    end else if (!run) begin
      m_en = 1'b0;
    end else begin
      m_elapsed++;
      if (m_elapsed == period_of(m_speed)) begin
        m_en      = 1'b1;
        m_elapsed = 0;
      end else begin
        m_en = 1'b0;
      end
    end
`ifdef RATE_DIVIDER_PULSE_COUNT_EN
    if (clr) m_pc = 16'h0000;
    else if (m_en && m_pc != 16'hFFFF) m_pc = m_pc + 16'd1;
`endif
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (Enable === m_en) else begin
      miscompares++;
      $error("FAIL %s enable: got %b expected %b", tag, Enable, m_en);
    end
    vectors++;
    assert (PulseCount === m_pc) else begin
      miscompares++;
      $error("FAIL %s pulse_count: got %h expected %h", tag, PulseCount, m_pc);
    end
  endtask

  task automatic step(input logic run, input logic clr, input logic [1:0] spd, input string tag);
    @(negedge Clock);
    Run = run; Clear = clr; Speed = spd;
    @(posedge Clock);
    model_edge(run, clr, spd);
    #1;
    check(tag);
  endtask

  // Releases reset on a falling edge so the following rising edge is the load edge.
  task automatic release_step(input logic run, input logic [1:0] spd, input string tag);
    @(negedge Clock);
    Resetn = 1'b1; Run = run; Clear = 1'b0; Speed = spd;
    @(posedge Clock);
    model_edge(run, 1'b0, spd);
    #1;
    check(tag);
  endtask

  initial begin
    int guard;
    logic [1:0] rs;
    vectors     = 0;
    miscompares = 0;
    Resetn = 1'b0; Run = 1'b0; Clear = 1'b0; Speed = 2'b00;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    check("reset");

    // Speed 01: load on edge 1, pulses after edges 5, 9, 13, 17.
    release_step(1'b1, 2'b01, "load_1hz");
    repeat (17) step(1'b1, 1'b0, 2'b01, "run_1hz");

    // Full rate, then switch to quarter rate mid-stream.
    repeat (8) step(1'b1, 1'b0, 2'b00, "full");
    repeat (20) step(1'b1, 1'b0, 2'b11, "quarter");

    // Half rate: 3 running cycles, 10 paused, then resume to the pulse and beyond.
    step(1'b1, 1'b0, 2'b10, "half_load");
    repeat (3) step(1'b1, 1'b0, 2'b10, "half_pre");
    repeat (10) step(1'b0, 1'b0, 2'b10, "half_pause");
    repeat (12) step(1'b1, 1'b0, 2'b10, "half_resume");

    // Clear on the edge where the pulse is due.
    step(1'b1, 1'b0, 2'b01, "clr_load");
    guard = 0;
    while (m_elapsed != period_of(2'b01) - 1 && guard < 10) begin
      step(1'b1, 1'b0, 2'b01, "clr_wait");
      guard++;
    end
    vectors++;
    assert (guard < 10) else begin
      miscompares++;
      $error("FAIL clr_wait_bound: got %0d expected <10", guard);
    end
    step(1'b1, 1'b1, 2'b01, "clr_edge");
    repeat (6) step(1'b1, 1'b0, 2'b01, "clr_after");

    // Asynchronous reset while Enable is high.
    repeat (3) step(1'b1, 1'b0, 2'b00, "pre_reset");
    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge Clock);
    #1;
    check("reset_held");
    release_step(1'b1, 2'b01, "reload");
    repeat (9) step(1'b1, 1'b0, 2'b01, "after_reset");

    // Long full-rate run: pulse counter saturates (or stays 0 without the feature).
    repeat (70000) step(1'b1, 1'b0, 2'b00, "saturate");
    step(1'b1, 1'b1, 2'b00, "sat_clear");
    repeat (4) step(1'b1, 1'b0, 2'b00, "post_clear");

    // Randomized run/clear/speed traffic.
    rs = 2'b01;
    for (int i = 0; i < 400; i++) begin
      logic r, c;
      if ($urandom_range(0, 15) == 0) rs = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      step(r, c, rs, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
